mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the core's single memory port between instruction fetch and load/store.
//  Sits between the multi-cycle control FSM/datapath and the external memory bus.
//  Serialises requests, drives byte lanes and extends load data.
//  Raises hold to freeze the control FSM while an access is outstanding.
// PARAMETERS
//  ADDR_W        32   memory address width
//  DATA_W        32   memory data width; fixed at 32, since lane logic assumes 4 bytes
//  TIMEOUT_CYC   255  cycles in BUSY before abort; used only with MEM_TIMEOUT_EN
// PORTS
//  clk        in   1       core clock; all state on rising edge
//  rstn       in   1       asynchronous active-low reset
//  if_req     in   1       fetch request; held high until if_done
//  if_addr    in   ADDR_W  fetch address, word aligned
//  if_done    out  1       one-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction
//  ls_req     in   1       load/store request; held high until ls_done
//  ls_we      in   1       1=store, 0=load
//  ls_addr    in   ADDR_W  byte address
//  ls_wdata   in   DATA_W  store data, right-justified
//  ls_type    in   2       00 byte, 01 half, 10 word (funct3[1:0])
//  ls_uns     in   1       1=zero-extend load (funct3[2])
//  ls_done    out  1       one-cycle pulse: access finished
//  ls_rdata   out  DATA_W  aligned, extended load data
//  ls_err     out  1       valid with ls_done: misaligned access or timeout
//  hold       out  1       freeze request to the control FSM
//  mem_req    out  1       bus request; held until mem_ack
//  mem_we     out  1       bus write strobe
//  mem_addr   out  ADDR_W  word-aligned bus address ({addr[31:2],2'b00})
//  mem_be     out  4       byte enables
//  mem_wdata  out  DATA_W  lane-replicated store data
//  mem_ack    in   1       bus completion; mem_rdata valid in the same cycle
//  mem_rdata  in   DATA_W  bus read data
// BEHAVIOUR
//  - Reset: FSM=IDLE. All outputs are 0, including hold, mem_req, done pulses and rdata.
//  - States: IDLE, IF_BUSY, LS_BUSY.
//    - IDLE->LS_BUSY on ls_req.
//    - IDLE->IF_BUSY on if_req with no ls_req.
//    - *_BUSY->IDLE on mem_ack.
//  - Priority: ls_req beats if_req when both are high in IDLE. The loser stays pending.
//  - Accept (IDLE->BUSY): latch addr/we/type/uns/wdata into registers. mem_* are driven from these registers.
//  - mem_req rises the cycle after accept and holds its value until mem_ack.
//  - Latency: with mem_ack in the first BUSY cycle, done pulses 2 cycles after req rises.
//  - On mem_ack: register rdata and pulse done next cycle. mem_req drops in the same edge.
//  - Back-to-back: a new request may be accepted in the cycle done pulses (IDLE).
//  - hold = (if_req & ~if_done) | (ls_req & ~ls_done). This is combinational and deasserts in the done cycle.
//  - mem_be lanes:
//    - byte: 1<<a[1:0]
//    - half: 4'b0011<<a[1:0]
//    - word: 4'b1111
//  - mem_wdata replication: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - Load extraction: shift mem_rdata right by a[1:0]*8, mask to the type, then sign- or zero-extend per ls_uns.
//  - Fetch: mem_be=4'hF, mem_we=0, no extension.
//  - Misaligned: half with a[0]=1, or word with a[1:0]!=0.
//    - No bus cycle is issued. FSM stays IDLE.
//    - ls_done and ls_err pulse the cycle after accept. ls_rdata=0.
//  - mem_ack while IDLE is ignored. if_req/ls_req dropped mid-BUSY: the bus cycle still completes, and the done pulse is still produced.
//  - Reset mid-BUSY: immediate return to IDLE with mem_req=0. The bus must tolerate an abandoned cycle.
// CONFIGURATION
//  - MEM_TIMEOUT_EN defined:
//    - An 8-bit counter clears on accept and counts each BUSY cycle without mem_ack.
//    - On reaching TIMEOUT_CYC: drop mem_req, return to IDLE, pulse done with rdata=0.
//    - ls_err=1 for LS timeouts. IF timeouts give if_rdata=0 (decodes as illegal).
//  - MEM_TIMEOUT_EN undefined: waits for mem_ack indefinitely. The counter is not built; ls_err flags misalignment only.
// STRUCTURE
//  - defines.v: state encodings (ARB_IDLE/ARB_IF/ARB_LS), LS_B/LS_H/LS_W codes, arbiter state bus width.
//  - Sub-module mem_lane_align: purely combinational; computes mem_be, mem_wdata, extended rdata and the misalign flag.
//  - Registers use the shared DFF primitive (CE + set value).
// TESTING
//  1 if_req, addr 0x100, ack on first BUSY cycle, rdata 0x00000013 -> if_done at cycle 2, if_rdata=0x00000013.
//  2 ls load byte, addr 0x203, uns=0, rdata 0x80FFFFFF -> mem_be=1000, ls_rdata=0xFFFFFF80.
//  3 ls store half, addr 0x302, wdata 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1.
//  4 if_req and ls_req high together -> LS served first; the fetch bus cycle starts after ls_done; hold high throughout.
//  5 ls load word, addr 0x101 -> no mem_req, ls_done+ls_err pulse next cycle, ls_rdata=0.
//  6 MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> mem_req drops after 4 BUSY cycles; ls_err=1; bench also checks rstn low mid-BUSY.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, load/store size codes,
// the latched request control word and the alignment rule.
package mem_port_arbiter_pkg;

    localparam int ARB_STATE_W = 2;

    localparam logic [ARB_STATE_W-1:0] ARB_IDLE = 2'd0;
    localparam logic [ARB_STATE_W-1:0] ARB_IF   = 2'd1;
    localparam logic [ARB_STATE_W-1:0] ARB_LS   = 2'd2;

    // funct3[1:0] size codes; 2'b11 is treated as a word
    localparam logic [1:0] LS_B = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_W = 2'b10;

    typedef struct packed {
        logic       we;
        logic [1:0] typ;
        logic       uns;
    } ls_ctl_t;

    function automatic logic ls_misaligned(input logic [1:0] typ, input logic [1:0] a_lo);
        case (typ)
            LS_B:    return 1'b0;
            LS_H:    return a_lo[0];
            default: return (a_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (fetch, load/store, hold) and bus-side signals of the arbiter.
// slave is the arbiter's view; master is the core plus memory driving it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [1:0]        ls_type;
    logic              ls_uns;
    logic              ls_done;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic              hold;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_type, ls_uns,
               mem_ack, mem_rdata,
        output if_done, if_rdata, ls_done, ls_rdata, ls_err, hold,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_type, ls_uns,
               mem_ack, mem_rdata,
        input  if_done, if_rdata, ls_done, ls_rdata, ls_err, hold,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane logic: enables, store replication, load shift/extend and misalignment; combinational.
// No state and no flow control; the arbiter decides when each output is sampled.
module mem_port_arbiter_lane_align
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        a_lo_i,
    input  logic [1:0]        type_i,
    input  logic              uns_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o
);

    logic [DATA_W-1:0] shifted;

    assign shifted = rdata_i >> {a_lo_i, 3'b000};

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (type_i)
            LS_B: begin
                be_o    = 4'b0001 << a_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
            end
            LS_H: begin
                be_o    = 4'b0011 << a_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    assign misalign_o = ls_misaligned(type_i, a_lo_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store onto one memory port (LS wins); done pulses 2 cycles after req with a first-cycle ack.
// Requesters are frozen via hold until done; MEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYC cycles without ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rstn,
    mem_port_arbiter_if.slave bus
);

    if (DATA_W != 32) begin : g_chk_data_w
        $error("mem_port_arbiter: DATA_W must be 32");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_chk_timeout
        $error("mem_port_arbiter: TIMEOUT_CYC must fit the 8-bit counter (1..255)");
    end

    logic [ARB_STATE_W-1:0] state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    ls_ctl_t                ctl_q, ctl_d;
    logic [3:0]             be_q, be_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]      ls_rdata_q, ls_rdata_d;
    logic                   if_done_q, if_done_d;
    logic                   ls_done_q, ls_done_d;
    logic                   ls_err_q, ls_err_d;

    logic                   busy;
    logic                   ls_pend;
    logic                   if_pend;
    logic                   timeout;

    logic [1:0]             al_lo;
    logic [1:0]             al_type;
    logic                   al_uns;
    logic [3:0]             al_be;
    logic [DATA_W-1:0]      al_wdata;
    logic [DATA_W-1:0]      al_rdata;
    logic                   al_misalign;

    assign busy = (state_q != ARB_IDLE);

    // A requester still high during its own done cycle is the finished access, not a new one.
    assign ls_pend = bus.ls_req & ~ls_done_q;
    assign if_pend = bus.if_req & ~if_done_q;

    // Lane logic sees the live LS request while idle (accept decision) and the latched one while busy.
    assign al_lo   = busy ? addr_q[1:0] : bus.ls_addr[1:0];
    assign al_type = busy ? ctl_q.typ   : bus.ls_type;
    assign al_uns  = busy ? ctl_q.uns   : bus.ls_uns;

    mem_port_arbiter_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .a_lo_i     (al_lo),
        .type_i     (al_type),
        .uns_i      (al_uns),
        .wdata_i    (bus.ls_wdata),
        .rdata_i    (bus.mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!busy) begin
            to_cnt_d = '0;
        end else if (!bus.mem_ack) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout = busy && !bus.mem_ack && (to_cnt_q == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        addr_d     = addr_q;
        ctl_d      = ctl_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        ls_err_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (ls_pend) begin
                    if (al_misalign) begin
                        ls_done_d  = 1'b1;
                        ls_err_d   = 1'b1;
                        ls_rdata_d = '0;
                    end else begin
                        state_d   = ARB_LS;
                        mem_req_d = 1'b1;
                        addr_d    = bus.ls_addr;
                        ctl_d     = '{we: bus.ls_we, typ: bus.ls_type, uns: bus.ls_uns};
                        be_d      = al_be;
                        wdata_d   = al_wdata;
                    end
                end else if (if_pend) begin
                    state_d   = ARB_IF;
                    mem_req_d = 1'b1;
                    addr_d    = bus.if_addr;
                    ctl_d     = '{we: 1'b0, typ: LS_W, uns: 1'b1};
                    be_d      = 4'hF;
                end
            end
            ARB_IF, ARB_LS: begin
                if (bus.mem_ack || timeout) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == ARB_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
                    end else begin
                        ls_done_d  = 1'b1;
                        ls_err_d   = !bus.mem_ack;
                        ls_rdata_d = bus.mem_ack ? al_rdata : '0;
                    end
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ARB_IDLE;
            mem_req_q  <= 1'b0;
            addr_q     <= '0;
            ctl_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            ls_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            addr_q     <= addr_d;
            ctl_q      <= ctl_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            ls_err_q   <= ls_err_d;
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_done   = ls_done_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_err    = ls_err_q;
    assign bus.hold      = if_pend | ls_pend;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = ctl_q.we;
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single accesses, scoreboard on the done pulses,
// plus hand sequences for arbitration, idle ack, dropped request, timeout/no-timeout and reset mid-access.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) tif ();

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (tif)
    );

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [1:0]  typ;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        chk_rd;
    } vec_t;

    typedef struct {
        logic        is_ls;
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
    } sb_t;

    vec_t vt[14];
    sb_t  sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic is_ls, we, input logic [1:0] typ, input logic uns,
                                input logic [31:0] addr, wdata, mrdata, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, e_rdata, input logic e_err, chk_rd);
        vec_t v;
        v.is_ls = is_ls; v.we = we; v.typ = typ; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        v.e_err = e_err; v.chk_rd = chk_rd;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        if (v.is_ls) begin
            tif.ls_req   = 1'b1;
            tif.ls_we    = v.we;
            tif.ls_addr  = v.addr;
            tif.ls_wdata = v.wdata;
            tif.ls_type  = v.typ;
            tif.ls_uns   = v.uns;
        end else begin
            tif.if_req  = 1'b1;
            tif.if_addr = v.addr;
        end
        sb_q.push_back('{v.is_ls, v.e_rdata, v.e_err, v.chk_rd});
    endtask

    task automatic drop();
        tif.if_req = 1'b0;
        tif.ls_req = 1'b0;
    endtask

    // Requester keeps req high through its done cycle, as the control FSM would.
    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] waddr;
        waddr = v.addr & 32'hFFFF_FFFC;
        issue(v);
        step();
        if (v.e_err) begin
            chk({nm, ":no_mem_req"}, tif.mem_req, 1'b0);
            chk({nm, ":err_done"}, tif.ls_done, 1'b1);
            chk({nm, ":hold_done"}, tif.hold, 1'b0);
        end else begin
            chk({nm, ":mem_req"}, tif.mem_req, 1'b1);
            chk({nm, ":mem_addr"}, tif.mem_addr, waddr);
            chk({nm, ":mem_be"}, tif.mem_be, v.e_be);
            chk({nm, ":mem_we"}, tif.mem_we, v.we);
            if (v.we) chk({nm, ":mem_wdata"}, tif.mem_wdata, v.e_wdata);
            chk({nm, ":hold_busy"}, tif.hold, 1'b1);
            tif.mem_ack   = 1'b1;
            tif.mem_rdata = v.mrdata;
            step();
            tif.mem_ack   = 1'b0;
            chk({nm, ":done"}, v.is_ls ? tif.ls_done : tif.if_done, 1'b1);
            chk({nm, ":req_drop"}, tif.mem_req, 1'b0);
            chk({nm, ":hold_done"}, tif.hold, 1'b0);
        end
        step();
        chk({nm, ":done_pulse"}, tif.if_done | tif.ls_done, 1'b0);
        chk({nm, ":no_reaccept"}, tif.mem_req, 1'b0);
        drop();
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sb_t e;
        if (rstn && (tif.if_done || tif.ls_done)) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: done pulse with nothing outstanding, if_done=%0b ls_done=%0b expected none",
                         tif.if_done, tif.ls_done);
            end else begin
                e = sb_q.pop_front();
                chk("sb_ls_done", tif.ls_done, e.is_ls);
                chk("sb_if_done", tif.if_done, !e.is_ls);
                if (e.chk_rd) chk("sb_rdata", e.is_ls ? tif.ls_rdata : tif.if_rdata, e.rdata);
                if (e.is_ls) chk("sb_ls_err", tif.ls_err, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tif.if_req = 1'b0; tif.if_addr = '0;
        tif.ls_req = 1'b0; tif.ls_we = 1'b0; tif.ls_addr = '0; tif.ls_wdata = '0;
        tif.ls_type = LS_W; tif.ls_uns = 1'b0;
        tif.mem_ack = 1'b0; tif.mem_rdata = '0;

        //              ls we typ   uns addr          wdata         mrdata        be    e_wdata       e_rdata       err chk
        vt[0]  = mk(1'b0, 1'b0, LS_W, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0013, 4'hF, 32'h0,         32'h0000_0013, 1'b0, 1'b1);
        vt[1]  = mk(1'b1, 1'b0, LS_B, 1'b0, 32'h0000_0203, 32'h0,         32'h80FF_FFFF, 4'h8, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b1);
        vt[2]  = mk(1'b1, 1'b1, LS_H, 1'b0, 32'h0000_0302, 32'h1234_ABCD, 32'h0,         4'hC, 32'hABCD_ABCD, 32'h0,         1'b0, 1'b0);
        vt[3]  = mk(1'b1, 1'b0, LS_H, 1'b1, 32'h0000_0402, 32'h0,         32'h8001_1234, 4'hC, 32'h0,         32'h0000_8001, 1'b0, 1'b1);
        vt[4]  = mk(1'b1, 1'b0, LS_H, 1'b0, 32'h0000_0400, 32'h0,         32'h1234_8001, 4'h3, 32'h0,         32'hFFFF_8001, 1'b0, 1'b1);
        vt[5]  = mk(1'b1, 1'b0, LS_B, 1'b1, 32'h0000_0501, 32'h0,         32'h0000_F100, 4'h2, 32'h0,         32'h0000_00F1, 1'b0, 1'b1);
        vt[6]  = mk(1'b1, 1'b0, LS_W, 1'b0, 32'h0000_0600, 32'h0,         32'hDEAD_BEEF, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1);
        vt[7]  = mk(1'b1, 1'b0, LS_W, 1'b0, 32'h0000_0101, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1'b1, 1'b1);
        vt[8]  = mk(1'b1, 1'b1, LS_B, 1'b0, 32'h0000_0701, 32'h0000_00A5, 32'h0,         4'h2, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b0);
        vt[9]  = mk(1'b1, 1'b1, LS_W, 1'b0, 32'h0000_0800, 32'hCAFE_F00D, 32'h0,         4'hF, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0);
        vt[10] = mk(1'b1, 1'b0, LS_B, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_007F, 4'h1, 32'h0,         32'h0000_007F, 1'b0, 1'b1);
        vt[11] = mk(1'b1, 1'b0, LS_H, 1'b1, 32'h0000_0203, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1'b1, 1'b1);
        vt[12] = mk(1'b1, 1'b1, LS_W, 1'b0, 32'h0000_0102, 32'h5555_5555, 32'h0,         4'h0, 32'h0,         32'h0,         1'b1, 1'b1);
        vt[13] = mk(1'b0, 1'b0, LS_W, 1'b0, 32'h0000_0204, 32'h0,         32'hFFFF_FFFF, 4'hF, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1);

        step();
        step();
        chk("rst_if_done", tif.if_done, 1'b0);
        chk("rst_if_rdata", tif.if_rdata, 32'h0);
        chk("rst_ls_done", tif.ls_done, 1'b0);
        chk("rst_ls_rdata", tif.ls_rdata, 32'h0);
        chk("rst_ls_err", tif.ls_err, 1'b0);
        chk("rst_hold", tif.hold, 1'b0);
        chk("rst_mem_req", tif.mem_req, 1'b0);
        chk("rst_mem_we", tif.mem_we, 1'b0);
        chk("rst_mem_addr", tif.mem_addr, 32'h0);
        chk("rst_mem_be", tif.mem_be, 4'h0);
        chk("rst_mem_wdata", tif.mem_wdata, 32'h0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Simultaneous requests: load/store first, fetch bus cycle right after ls_done.
        tif.ls_req = 1'b1; tif.ls_we = 1'b0; tif.ls_addr = 32'h900; tif.ls_type = LS_W; tif.ls_uns = 1'b0;
        tif.if_req = 1'b1; tif.if_addr = 32'hA00;
        sb_q.push_back('{1'b1, 32'h1111_1111, 1'b0, 1'b1});
        sb_q.push_back('{1'b0, 32'h2222_2222, 1'b0, 1'b1});
        step();
        chk("both:ls_first_addr", tif.mem_addr, 32'h900);
        chk("both:hold1", tif.hold, 1'b1);
        tif.mem_ack = 1'b1; tif.mem_rdata = 32'h1111_1111;
        step();
        tif.mem_ack = 1'b0;
        chk("both:ls_done", tif.ls_done, 1'b1);
        chk("both:hold2", tif.hold, 1'b1);
        chk("both:req_gap", tif.mem_req, 1'b0);
        step();
        tif.ls_req = 1'b0;
        chk("both:if_req", tif.mem_req, 1'b1);
        chk("both:if_addr", tif.mem_addr, 32'hA00);
        chk("both:if_be", tif.mem_be, 4'hF);
        chk("both:if_we", tif.mem_we, 1'b0);
        chk("both:hold3", tif.hold, 1'b1);
        tif.mem_ack = 1'b1; tif.mem_rdata = 32'h2222_2222;
        step();
        tif.mem_ack = 1'b0;
        chk("both:if_done", tif.if_done, 1'b1);
        chk("both:hold4", tif.hold, 1'b0);
        step();
        drop();

        // Stray ack while idle does nothing.
        tif.mem_ack = 1'b1; tif.mem_rdata = 32'h0BAD_0BAD;
        step();
        step();
        tif.mem_ack = 1'b0;
        chk("idle_ack:mem_req", tif.mem_req, 1'b0);
        chk("idle_ack:done", tif.if_done | tif.ls_done, 1'b0);

        // Request withdrawn mid-access: bus cycle still completes with a done pulse.
        v = mk(1'b1, 1'b0, LS_B, 1'b1, 32'h0000_0D02, 32'h0, 32'h00AB_0000, 4'h4, 32'h0, 32'h0000_00AB, 1'b0, 1'b1);
        issue(v);
        step();
        drop();
        for (int i = 0; i < 2; i++) begin
            chk("withdraw:req_held", tif.mem_req, 1'b1);
            step();
        end
        chk("withdraw:be", tif.mem_be, 4'h4);
        tif.mem_ack = 1'b1; tif.mem_rdata = v.mrdata;
        step();
        tif.mem_ack = 1'b0;
        chk("withdraw:done", tif.ls_done, 1'b1);
        step();

`ifdef MEM_TIMEOUT_EN
        // No ack: mem_req high for exactly 4 BUSY cycles, then an error completion with zero data.
        v = mk(1'b1, 1'b0, LS_W, 1'b0, 32'h0000_0B00, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
        issue(v);
        tif.mem_rdata = 32'h7777_7777;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_ls:req_busy", tif.mem_req, 1'b1);
            step();
        end
        chk("tmo_ls:req_drop", tif.mem_req, 1'b0);
        chk("tmo_ls:done", tif.ls_done, 1'b1);
        step();
        drop();
        v = mk(1'b0, 1'b0, LS_W, 1'b0, 32'h0000_0B04, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(v);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_if:req_busy", tif.mem_req, 1'b1);
            step();
        end
        chk("tmo_if:req_drop", tif.mem_req, 1'b0);
        chk("tmo_if:done", tif.if_done, 1'b1);
        step();
        drop();
`else
        // Without the timeout the access waits for its ack indefinitely.
        v = mk(1'b1, 1'b0, LS_W, 1'b0, 32'h0000_0B00, 32'h0, 32'h3C3C_3C3C, 4'hF, 32'h0, 32'h3C3C_3C3C, 1'b0, 1'b1);
        issue(v);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("wait:req_busy", tif.mem_req, 1'b1);
            step();
        end
        chk("wait:no_done", tif.ls_done, 1'b0);
        tif.mem_ack = 1'b1; tif.mem_rdata = v.mrdata;
        step();
        tif.mem_ack = 1'b0;
        chk("wait:done", tif.ls_done, 1'b1);
        step();
        drop();
`endif

        // Reset in the middle of a fetch: bus request drops at once, arbiter recovers.
        v = mk(1'b0, 1'b0, LS_W, 1'b0, 32'h0000_0C00, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(v);
        step();
        chk("rst_busy:req_before", tif.mem_req, 1'b1);
        #2;
        rstn = 1'b0;
        drop();
        #1;
        chk("rst_busy:req_after", tif.mem_req, 1'b0);
        chk("rst_busy:hold", tif.hold, 1'b0);
        void'(sb_q.pop_back());
        step();
        step();
        rstn = 1'b1;
        step();
        run_vec(vt[0], "post_reset");

        step();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
